// File: rtl/mips_fetch_unit_if.sv
// mips_fetch_unit_if: fetch-stage bus (imem, control-unit inputs, PC/debug outputs); BRANCH_STATS_EN adds taken_count
interface mips_fetch_unit_if #(
  parameter int IMEM_AW = 6,
  parameter int COUNT_W = 16
);
  logic               run_sw;
  logic               step_btn;
  logic [31:0]        instr_in;
  logic               zero;
  logic               branch;
  logic               bne;
  logic               jump;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        pc;
  logic [31:0]        pc_plus4;
  logic [31:0]        instr;
  logic [5:0]         op;
  logic [5:0]         funct;
  logic               advance;
  logic               halted;
  logic [COUNT_W-1:0] instr_count;
`ifdef BRANCH_STATS_EN
  logic [COUNT_W-1:0] taken_count;
`endif
  modport master (
    input  run_sw, step_btn, instr_in, zero, branch, bne, jump,
    output imem_addr, pc, pc_plus4, instr, op, funct, advance, halted, instr_count
`ifdef BRANCH_STATS_EN
    , output taken_count
`endif
  );
  modport slave (
    output run_sw, step_btn, instr_in, zero, branch, bne, jump,
    input  imem_addr, pc, pc_plus4, instr, op, funct, advance, halted, instr_count
`ifdef BRANCH_STATS_EN
    , input taken_count
`endif
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: PC/fetch stage with run/step/halt debug FSM; BRANCH_STATS_EN adds a taken-branch/jump counter
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMEM_AW   = 6,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int          COUNT_W   = 16
) (
  input logic              clk,
  input logic              rst_n,
  mips_fetch_unit_if.master bus
);
  localparam logic [1:0] PAUSE  = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;
  logic [31:0]        pc_q, pc_d;
  logic [1:0]         state_q, state_d;
  logic [2:0]         sync_q, sync_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]        pc_plus4, seimm, br_target, j_target, next_pc;
  logic               taken, is_halt, step_edge, advance;
`ifdef BRANCH_STATS_EN
  logic [COUNT_W-1:0] tcnt_q, tcnt_d;
`endif
  // next-PC selection: jump beats a taken branch beats sequential
  always_comb begin
    pc_plus4  = pc_q + 32'd4;
    seimm     = {{16{bus.instr_in[15]}}, bus.instr_in[15:0]};
    br_target = pc_plus4 + {seimm[29:0], 2'b00};
    j_target  = {pc_plus4[31:28], bus.instr_in[25:0], 2'b00};
    taken     = (bus.branch & bus.zero) | (bus.bne & ~bus.zero);
    next_pc   = bus.jump ? j_target : taken ? br_target : pc_plus4;
  end
  // run/step/halt control; a halt word is never retired so the PC keeps pointing at it
  always_comb begin
    is_halt   = (bus.instr_in == HALT_WORD);
    step_edge = sync_q[1] & ~sync_q[2];
    state_d   = state_q;
    advance   = 1'b0;
    unique case (state_q)
      PAUSE: begin
        state_d = is_halt ? HALTED : bus.run_sw ? RUN : PAUSE;
        advance = ~is_halt & ~bus.run_sw & step_edge;
      end
      RUN: begin
        state_d = is_halt ? HALTED : bus.run_sw ? RUN : PAUSE;
        advance = ~is_halt & bus.run_sw;
      end
      default: state_d = HALTED;
    endcase
  end
  // register next-state: PC and counters move only on a retiring cycle
  always_comb begin
    pc_d   = advance ? next_pc : pc_q;
    cnt_d  = cnt_q + COUNT_W'(advance);
    sync_d = {sync_q[1:0], bus.step_btn};
`ifdef BRANCH_STATS_EN
    tcnt_d = tcnt_q + COUNT_W'(advance & (taken | bus.jump));
`endif
  end
  // state flops with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= PAUSE;
      sync_q  <= '0;
      cnt_q   <= '0;
`ifdef BRANCH_STATS_EN
      tcnt_q  <= '0;
`endif
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
`ifdef BRANCH_STATS_EN
      tcnt_q  <= tcnt_d;
`endif
    end
  end
  assign bus.imem_addr   = pc_q[IMEM_AW+1:2];
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.instr       = bus.instr_in;
  assign bus.op          = bus.instr_in[31:26];
  assign bus.funct       = bus.instr_in[5:0];
  assign bus.advance     = advance;
  assign bus.halted      = (state_q == HALTED);
  assign bus.instr_count = cnt_q;
`ifdef BRANCH_STATS_EN
  assign bus.taken_count = tcnt_q;
`endif
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: directed + random check of mips_fetch_unit against a behavioural model (BRANCH_STATS_EN aware)
module tb_mips_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] HALT     = 32'hFFFF_FFFF;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mips_fetch_unit_if #(.IMEM_AW(6), .COUNT_W(16)) bus ();
  mips_fetch_unit #(.RESET_PC(RESET_PC), .IMEM_AW(6), .HALT_WORD(HALT), .COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] m_pc;
  bit          m_run, m_halt;
  logic [15:0] m_cnt, m_tcnt;
  bit   [2:0]  m_hist;
  logic [31:0] prog [3];
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                           input bit z, input bit b, input bit n, input bit j);
    logic [31:0] p4;
    int off;
    p4 = p + 32'd4;
    off = $signed(ins[15:0]);
    if (j) return {p4[31:28], ins[25:0], 2'b00};
    if ((b && z) || (n && !z)) return p4 + 32'(off * 4);
    return p4;
  endfunction
  task automatic cyc(input logic [31:0] ins, input bit z, input bit b, input bit n, input bit j,
                     input bit rs, input bit sb);
    bit adv, step_now, is_halt, tk;
    bus.instr_in = ins; bus.zero = z; bus.branch = b; bus.bne = n; bus.jump = j;
    bus.run_sw = rs; bus.step_btn = sb;
    #1;
    is_halt  = (ins == HALT);
    step_now = m_hist[1] && !m_hist[2];
    tk       = (b && z) || (n && !z);
    adv      = 1'b0;
    if (!m_halt && !is_halt) adv = m_run ? rs : (!rs && step_now);
    check("pc", bus.pc, m_pc);
    check("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
    check("imem_addr", 32'(bus.imem_addr), 32'(m_pc[7:2]));
    check("op_funct", {20'd0, bus.op, bus.funct}, {20'd0, ins[31:26], ins[5:0]});
    check("instr", bus.instr, ins);
    check("advance", 32'(bus.advance), 32'(adv));
    check("halted", 32'(bus.halted), 32'(m_halt));
    check("instr_count", 32'(bus.instr_count), 32'(m_cnt));
`ifdef BRANCH_STATS_EN
    check("taken_count", 32'(bus.taken_count), 32'(m_tcnt));
`endif
    @(posedge clk);
    if (adv) begin
      m_pc = ref_next(m_pc, ins, z, b, n, j);
      m_cnt++;
      if (tk || j) m_tcnt++;
    end
    if (!m_halt) begin
      if (is_halt) begin m_halt = 1'b1; m_run = 1'b0; end
      else m_run = rs;
    end
    m_hist = {m_hist[1:0], sb};
    #1;
  endtask
  task automatic do_reset();
    bus.run_sw = 1'b0; bus.step_btn = 1'b0; bus.instr_in = '0;
    bus.zero = 1'b0; bus.branch = 1'b0; bus.bne = 1'b0; bus.jump = 1'b0;
    rst_n = 1'b0;
    #1;
    m_pc = RESET_PC; m_run = 1'b0; m_halt = 1'b0; m_cnt = '0; m_tcnt = '0; m_hist = '0;
    check("rst_pc", bus.pc, RESET_PC);
    check("rst_count", 32'(bus.instr_count), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_advance", 32'(bus.advance), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bit sb;
    prog[0] = 32'h2008_0005;
    prog[1] = 32'h0109_5020;
    prog[2] = HALT;
    do_reset();
    for (int i = 0; i < 8; i++) cyc(prog[m_pc[3:2]], 0, 0, 0, 0, 1, 0);
    check("prog_pc", bus.pc, 32'h8);
    check("prog_halted", 32'(bus.halted), 32'd1);
    check("prog_count", 32'(bus.instr_count), 32'd2);
    do_reset();
    cyc(32'h0, 0, 0, 0, 0, 1, 0);
    cyc(32'h0800_0004, 0, 0, 0, 1, 1, 0);
    check("j_0x10", bus.pc, 32'h10);
    cyc(32'h1022_FFFC, 1, 1, 0, 0, 1, 0);
    check("beq_taken", bus.pc, 32'h4);
    cyc(32'h0800_0004, 0, 0, 0, 1, 1, 0);
    cyc(32'h1022_FFFC, 0, 1, 0, 0, 1, 0);
    check("beq_not_taken", bus.pc, 32'h14);
    cyc(32'h0800_0008, 0, 0, 0, 1, 1, 0);
    cyc(32'h1422_0003, 0, 0, 1, 0, 1, 0);
    check("bne_taken", bus.pc, 32'h30);
    cyc(32'h0800_0040, 1, 1, 1, 1, 1, 0);
    check("jump_priority", bus.pc, 32'h100);
    cyc(32'h0800_0000, 0, 0, 0, 1, 1, 0);
    cyc(32'h1000_FFFE, 1, 1, 0, 0, 1, 0);
    check("branch_under_zero", bus.pc, 32'hFFFF_FFFC);
    check("imem_alias", 32'(bus.imem_addr), 32'd63);
    cyc(32'h0, 0, 0, 0, 0, 1, 0);
    check("pc_wrap", bus.pc, 32'h0);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(32'h0, 0, 0, 0, 0, 0, 1);
      check("step_latency", bus.pc, (i < 2) ? 32'h0 : 32'h4);
    end
    for (int i = 0; i < 4; i++) cyc(32'h0, 0, 0, 0, 0, 0, 0);
    check("step_once_pc", bus.pc, 32'h4);
    check("step_once_count", 32'(bus.instr_count), 32'd1);
    do_reset();
    cyc(32'h0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) cyc(32'h0, 0, 0, 0, 0, 1, 0);
    check("run_pc_1c", bus.pc, 32'h1C);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pc", bus.pc, RESET_PC);
    check("async_rst_count", 32'(bus.instr_count), 32'd0);
    check("async_rst_paused", 32'(bus.advance), 32'd0);
    do_reset();
    cyc(32'h0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(32'h1022_0000, 1, 1, 0, 0, 1, 0);
    cyc(32'h1422_0000, 1, 0, 1, 0, 1, 0);
    cyc(32'h0800_0010, 0, 0, 0, 1, 1, 0);
    check("stats_pc", bus.pc, 32'h40);
`ifdef BRANCH_STATS_EN
    check("stats_taken", 32'(bus.taken_count), 32'd4);
`endif
    do_reset();
    sb = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(0, 199) == 0) ins = HALT;
      if ($urandom_range(0, 3) == 0) sb = ~sb;
      cyc(ins, 1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) != 0), sb);
      if (m_halt && $urandom_range(0, 3) == 0) begin
        do_reset();
        sb = 1'b0;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
